// File: rtl/jogador_automatico.sv
// jogador_automatico
// ------------------
// Automatic player for a memory/sequence game. After a start request it
// pulses `iniciar`, waits for the game to settle, then plays rounds 0..15.
// Round r replays the first r+1 values of a fixed sequence. Each value is
// held for HOLD cycles and followed by RELEASE cycles of no press. An
// optional error injection corrupts the last press of one chosen round.
// The game's win/loss inputs end the run at any point. If no result
// arrives within RESULT_WAIT cycles after the last press, the run ends
// with a timeout.
//
// Ports
//   clock        in   single rising-edge clock
//   reset        in   synchronous, active-high reset
//   comecar      in   start request (accepted only in IDLE or FIM)
//   erro_en      in   error injection enable, latched on start
//   erro_rodada  in   round receiving the wrong press, latched on start
//   ganhou       in   game reports a win
//   perdeu       in   game reports a loss
//   iniciar      out  start pulse to the game
//   botoes       out  one-hot button press, 0000 when idle
//   ocupado      out  run in progress (not IDLE and not FIM)
//   fim          out  run finished
//   venceu       out  run ended with a win (valid while fim=1)
//   expirou      out  run ended by result timeout (valid while fim=1)
//   rodada       out  current round 0..15
//   indice       out  press index within the round 0..rodada
//   db_estado    out  debug state code
module jogador_automatico #(
  parameter int INIT_PULSE  = 5,
  parameter int START_WAIT  = 2005,
  parameter int HOLD        = 100,
  parameter int RELEASE     = 100,
  parameter int RESULT_WAIT = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       comecar,
  input  logic       erro_en,
  input  logic [3:0] erro_rodada,
  input  logic       ganhou,
  input  logic       perdeu,
  output logic       iniciar,
  output logic [3:0] botoes,
  output logic       ocupado,
  output logic       fim,
  output logic       venceu,
  output logic       expirou,
  output logic [3:0] rodada,
  output logic [3:0] indice,
  output logic [3:0] db_estado
);

  localparam int TW = 32;

  // Each timer is loaded with (duration - 1) on state entry and the state is
  // left when it reaches zero, so the state lasts exactly `duration` cycles.
  // A duration of 0 is clamped to 1.
  localparam logic [TW-1:0] LD_INIT   = TW'(((INIT_PULSE  < 1) ? 1 : INIT_PULSE)  - 1);
  localparam logic [TW-1:0] LD_ESPERA = TW'(((START_WAIT  < 1) ? 1 : START_WAIT)  - 1);
  localparam logic [TW-1:0] LD_HOLD   = TW'(((HOLD        < 1) ? 1 : HOLD)        - 1);
  localparam logic [TW-1:0] LD_SOLTA  = TW'(((RELEASE     < 1) ? 1 : RELEASE)     - 1);
  localparam logic [TW-1:0] LD_AGUARD = TW'(((RESULT_WAIT < 1) ? 1 : RESULT_WAIT) - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_INICIA  = 4'd1,
    S_ESPERA  = 4'd2,
    S_APERTA  = 4'd3,
    S_SOLTA   = 4'd4,
    S_AGUARDA = 4'd5,
    S_FIM     = 4'd15
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    rodada_q, rodada_d;
  logic [3:0]    indice_q, indice_d;
  logic          erro_en_q, erro_en_d;
  logic [3:0]    erro_rodada_q, erro_rodada_d;
  logic          iniciar_q, iniciar_d;
  logic [3:0]    botoes_q, botoes_d;
  logic          ocupado_q, ocupado_d;
  logic          fim_q, fim_d;
  logic          venceu_q, venceu_d;
  logic          expirou_q, expirou_d;

  // Sequence value for a press index: 0001 0010 0100 1000 0100 0010, repeating.
  function automatic logic [3:0] seq_value(input logic [3:0] idx);
    logic [3:0] v;
    case (idx)
      4'd0, 4'd6, 4'd12:  v = 4'b0001;
      4'd1, 4'd7, 4'd13:  v = 4'b0010;
      4'd2, 4'd8, 4'd14:  v = 4'b0100;
      4'd3, 4'd9, 4'd15:  v = 4'b1000;
      4'd4, 4'd10:        v = 4'b0100;
      4'd5, 4'd11:        v = 4'b0010;
      default:            v = 4'b0000;
    endcase
    return v;
  endfunction

  // Wrong press used for error injection: the correct one-hot rotated left.
  function automatic logic [3:0] rotl1(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  // Next-state, counters and Moore outputs (outputs derived from the next state).
  always_comb begin
    estado_d      = estado_q;
    rodada_d      = rodada_q;
    indice_d      = indice_q;
    erro_en_d     = erro_en_q;
    erro_rodada_d = erro_rodada_q;
    venceu_d      = venceu_q;
    expirou_d     = expirou_q;
    if (timer_q != {TW{1'b0}}) begin
      timer_d = timer_q - {{(TW-1){1'b0}}, 1'b1};
    end else begin
      timer_d = timer_q;
    end

    case (estado_q)
      S_IDLE, S_FIM: begin
        if (comecar) begin
          estado_d      = S_INICIA;
          timer_d       = LD_INIT;
          rodada_d      = 4'd0;
          indice_d      = 4'd0;
          erro_en_d     = erro_en;
          erro_rodada_d = erro_rodada;
          venceu_d      = 1'b0;
          expirou_d     = 1'b0;
        end else begin
          estado_d = estado_q;
        end
      end
      S_INICIA, S_ESPERA, S_APERTA, S_SOLTA, S_AGUARDA: begin
        if (ganhou || perdeu) begin
          // A result ends the run immediately; win wins over loss.
          estado_d  = S_FIM;
          venceu_d  = ganhou;
          expirou_d = 1'b0;
        end else if (timer_q == {TW{1'b0}}) begin
          case (estado_q)
            S_INICIA: begin
              estado_d = S_ESPERA;
              timer_d  = LD_ESPERA;
            end
            S_ESPERA: begin
              estado_d = S_APERTA;
              timer_d  = LD_HOLD;
            end
            S_APERTA: begin
              estado_d = S_SOLTA;
              timer_d  = LD_SOLTA;
            end
            S_SOLTA: begin
              if (indice_q < rodada_q) begin
                estado_d = S_APERTA;
                timer_d  = LD_HOLD;
                indice_d = indice_q + 4'd1;
              end else if (rodada_q != 4'd15) begin
                estado_d = S_APERTA;
                timer_d  = LD_HOLD;
                rodada_d = rodada_q + 4'd1;
                indice_d = 4'd0;
              end else begin
                estado_d = S_AGUARDA;
                timer_d  = LD_AGUARD;
              end
            end
            S_AGUARDA: begin
              estado_d  = S_FIM;
              venceu_d  = 1'b0;
              expirou_d = 1'b1;
            end
            default: begin
              estado_d = S_IDLE;
            end
          endcase
        end else begin
          estado_d = estado_q;
        end
      end
      default: begin
        estado_d = S_IDLE;
      end
    endcase

    iniciar_d = (estado_d == S_INICIA);
    fim_d     = (estado_d == S_FIM);
    ocupado_d = (estado_d != S_IDLE) && (estado_d != S_FIM);
    if (estado_d == S_APERTA) begin
      if (erro_en_d && (rodada_d == erro_rodada_d) && (indice_d == rodada_d)) begin
        botoes_d = rotl1(seq_value(indice_d));
      end else begin
        botoes_d = seq_value(indice_d);
      end
    end else begin
      botoes_d = 4'b0000;
    end
  end

  // State, counters and registered outputs; reset overrides everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q      <= S_IDLE;
      timer_q       <= {TW{1'b0}};
      rodada_q      <= 4'd0;
      indice_q      <= 4'd0;
      erro_en_q     <= 1'b0;
      erro_rodada_q <= 4'd0;
      iniciar_q     <= 1'b0;
      botoes_q      <= 4'd0;
      ocupado_q     <= 1'b0;
      fim_q         <= 1'b0;
      venceu_q      <= 1'b0;
      expirou_q     <= 1'b0;
    end else begin
      estado_q      <= estado_d;
      timer_q       <= timer_d;
      rodada_q      <= rodada_d;
      indice_q      <= indice_d;
      erro_en_q     <= erro_en_d;
      erro_rodada_q <= erro_rodada_d;
      iniciar_q     <= iniciar_d;
      botoes_q      <= botoes_d;
      ocupado_q     <= ocupado_d;
      fim_q         <= fim_d;
      venceu_q      <= venceu_d;
      expirou_q     <= expirou_d;
    end
  end

  assign iniciar   = iniciar_q;
  assign botoes    = botoes_q;
  assign ocupado   = ocupado_q;
  assign fim       = fim_q;
  assign venceu    = venceu_q;
  assign expirou   = expirou_q;
  assign rodada    = rodada_q;
  assign indice    = indice_q;
  assign db_estado = estado_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// Scoreboard bench for jogador_automatico. Stimulus pushes every expected
// output change (with its absolute cycle) into a queue; the monitor pops one
// entry each time the DUT's outputs change and compares all fields.
module tb_jogador_automatico;

  logic       clock = 1'b0;
  logic       reset, comecar, erro_en, ganhou, perdeu;
  logic [3:0] erro_rodada;
  logic       iniciar, ocupado, fim, venceu, expirou;
  logic [3:0] botoes, rodada, indice, db_estado;

  jogador_automatico dut (
    .clock(clock), .reset(reset), .comecar(comecar), .erro_en(erro_en),
    .erro_rodada(erro_rodada), .ganhou(ganhou), .perdeu(perdeu),
    .iniciar(iniciar), .botoes(botoes), .ocupado(ocupado), .fim(fim),
    .venceu(venceu), .expirou(expirou), .rodada(rodada), .indice(indice),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [3:0] est;
    logic       ini;
    logic [3:0] bot;
    logic       ocu;
    logic       f;
    logic       v;
    logic       x;
    logic [3:0] rod;
    logic [3:0] idx;
  } ev_t;

  ev_t        exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         mon_en = 1'b0;
  logic [3:0] last_rod, last_idx;
  localparam int BIG = 32'h7fff_ffff;

  function automatic logic [3:0] pat(input int i);
    case (i % 6)
      0:       return 4'b0001;
      1:       return 4'b0010;
      2:       return 4'b0100;
      3:       return 4'b1000;
      4:       return 4'b0100;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic bit differs(input ev_t a, input ev_t b);
    return (a.est !== b.est) || (a.ini !== b.ini) || (a.bot !== b.bot) ||
           (a.ocu !== b.ocu) || (a.f !== b.f) || (a.v !== b.v) ||
           (a.x !== b.x) || (a.rod !== b.rod) || (a.idx !== b.idx);
  endfunction

  // Push one expected output change, but only if it precedes the interruption cycle.
  task automatic add(input int c, input int stop, input logic [3:0] est, input logic ini,
                     input logic [3:0] bot, input logic [3:0] rod, input logic [3:0] idx,
                     input logic f, input logic v, input logic x);
    ev_t e;
    if (c < stop) begin
      e.c = c; e.est = est; e.ini = ini; e.bot = bot;
      e.ocu = (est != 4'd0) && (est != 4'd15);
      e.f = f; e.v = v; e.x = x; e.rod = rod; e.idx = idx;
      exp_q.push_back(e);
      last_rod = rod;
      last_idx = idx;
    end
  endtask

  // Expected changes of a whole run whose start is sampled at edge c0.
  task automatic gen_run(input int c0, input int stop, input bit ee, input logic [3:0] er);
    int t;
    logic [3:0] v;
    add(c0, stop, 4'd1, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    add(c0 + 5, stop, 4'd2, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    t = c0 + 2010;
    for (int r = 0; r < 16; r++) begin
      for (int i = 0; i <= r; i++) begin
        v = pat(i);
        if (ee && (r == int'(er)) && (i == r)) v = {v[2:0], v[3]};
        add(t, stop, 4'd3, 1'b0, v, 4'(r), 4'(i), 1'b0, 1'b0, 1'b0);
        add(t + 100, stop, 4'd4, 1'b0, 4'd0, 4'(r), 4'(i), 1'b0, 1'b0, 1'b0);
        t = t + 200;
      end
    end
    add(t, stop, 4'd5, 1'b0, 4'd0, 4'd15, 4'd15, 1'b0, 1'b0, 1'b0);
    add(t + 1000, stop, 4'd15, 1'b0, 4'd0, 4'd15, 4'd15, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) step(1);
  endtask

  // Drive a result so that it is sampled at edge e.
  task automatic result_at(input int e, input logic g, input logic p);
    wait_until(e - 1);
    ganhou = g; perdeu = p;
    step(1);
    ganhou = 1'b0; perdeu = 1'b0;
  endtask

  task automatic start_pulse(input logic ee, input logic [3:0] er);
    erro_en = ee; erro_rodada = er; comecar = 1'b1;
    step(1);
    comecar = 1'b0; erro_en = 1'b0; erro_rodada = 4'd0;
  endtask

  // Monitor: every change of the outputs is one event checked against the queue.
  initial begin
    ev_t cur, prev, w;
    bit first;
    first = 1'b1;
    wait (mon_en);
    forever begin
      @(negedge clock);
      cur.c = cyc; cur.est = db_estado; cur.ini = iniciar; cur.bot = botoes;
      cur.ocu = ocupado; cur.f = fim; cur.v = venceu; cur.x = expirou;
      cur.rod = rodada; cur.idx = indice;
      if (first || differs(cur, prev)) begin
        first = 1'b0;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change: got cyc=%0d est=%0d ini=%b bot=%b rod=%0d idx=%0d fim=%b, required no change",
                   cur.c, cur.est, cur.ini, cur.bot, cur.rod, cur.idx, cur.f);
        end else begin
          w = exp_q.pop_front();
          if (differs(cur, w) || (cur.c != w.c)) begin
            n_bad++;
            $display("FAIL event: got cyc=%0d est=%0d ini=%b bot=%b ocu=%b fim=%b ven=%b exp=%b rod=%0d idx=%0d; required cyc=%0d est=%0d ini=%b bot=%b ocu=%b fim=%b ven=%b exp=%b rod=%0d idx=%0d",
                     cur.c, cur.est, cur.ini, cur.bot, cur.ocu, cur.f, cur.v, cur.x, cur.rod, cur.idx,
                     w.c, w.est, w.ini, w.bot, w.ocu, w.f, w.v, w.x, w.rod, w.idx);
          end
        end
      end
      prev = cur;
    end
  end

  initial begin
    #950000;
    $display("FAIL watchdog: simulation exceeded cycle budget at cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int c0, e;
    reset = 1'b1; comecar = 1'b0; erro_en = 1'b0; erro_rodada = 4'd0;
    ganhou = 1'b0; perdeu = 1'b0;
    step(3);
    // Reset state: everything zero.
    add(cyc, BIG, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    step(1);
    reset = 1'b0;
    step(5);

    // Rounds 0..2, an ignored start mid-run, then a loss in round 3.
    c0 = cyc + 1;
    e  = c0 + 2010 + 1200 + 50;
    gen_run(c0, e, 1'b0, 4'd0);
    start_pulse(1'b0, 4'd0);
    wait_until(c0 + 2010 + 300);
    start_pulse(1'b1, 4'd1);
    add(e, BIG, 4'd15, 1'b0, 4'd0, last_rod, last_idx, 1'b1, 1'b0, 1'b0);
    result_at(e, 1'b0, 1'b1);
    step(10);

    // Error injection in round 2; loss on the edge after the wrong press.
    c0 = cyc + 1;
    e  = c0 + 3011;
    gen_run(c0, e, 1'b1, 4'd2);
    start_pulse(1'b1, 4'd2);
    add(e, BIG, 4'd15, 1'b0, 4'd0, last_rod, last_idx, 1'b1, 1'b0, 1'b0);
    result_at(e, 1'b0, 1'b1);
    step(10);

    // Full run, win and loss together 10 cycles into AGUARDA: win has priority.
    c0 = cyc + 1;
    e  = c0 + 29210 + 10;
    gen_run(c0, e, 1'b0, 4'd0);
    start_pulse(1'b0, 4'd0);
    add(e, BIG, 4'd15, 1'b0, 4'd0, last_rod, last_idx, 1'b1, 1'b1, 1'b0);
    result_at(e, 1'b1, 1'b1);
    step(10);

    // Restart from FIM, full run with no result: timeout.
    c0 = cyc + 1;
    gen_run(c0, BIG, 1'b0, 4'd0);
    start_pulse(1'b0, 4'd0);
    wait_until(c0 + 29210 + 1000 + 5);

    // Reset in the middle of the first press of round 5.
    c0 = cyc + 1;
    e  = c0 + 2010 + 15 * 200 + 50;
    gen_run(c0, e, 1'b0, 4'd0);
    start_pulse(1'b0, 4'd0);
    wait_until(c0 + 2010 + 400);
    start_pulse(1'b0, 4'd0);
    add(e, BIG, 4'd0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    wait_until(e - 1);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(10);

    while (exp_q.size() > 0) begin
      ev_t w;
      w = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_event: got no change, required cyc=%0d est=%0d bot=%b rod=%0d idx=%0d",
               w.c, w.est, w.bot, w.rod, w.idx);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
